// File: rtl/rf_riscv_pkg.sv
// Shared types and default sizing for the multi-port register file.
package rf_riscv_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 2;
    localparam int RF_ADDR_W = $clog2(RF_DEPTH);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : rf_riscv_pkg

// File: rtl/rf_init_ctrl.sv
// Post-reset clear sweep: walks registers 1..DEPTH-1 once, then raises ready.
module rf_init_ctrl
    import rf_riscv_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              clear_en_o,
    output logic [ADDR_W-1:0] clear_addr_o,
    output logic              ready_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    rf_state_e         state_r;
    logic [ADDR_W-1:0] clr_idx_r;
    logic              clear_en_r;
    logic              ready_r;

    // Sweep FSM; register 0 is never stored so the sweep starts at index 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= INIT;
            clr_idx_r  <= FIRST_IDX;
            clear_en_r <= 1'b1;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    if (clr_idx_r == LAST_IDX) begin
                        state_r    <= RUN;
                        clear_en_r <= 1'b0;
                        ready_r    <= 1'b1;
                    end else begin
                        clr_idx_r <= clr_idx_r + ADDR_W'(1);
                    end
                end
                RUN: begin
                    state_r    <= RUN;
                    clear_en_r <= 1'b0;
                    ready_r    <= 1'b1;
                end
                default: begin
                    state_r    <= INIT;
                    clr_idx_r  <= FIRST_IDX;
                    clear_en_r <= 1'b1;
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

    assign clear_en_o   = clear_en_r;
    assign clear_addr_o = clr_idx_r;
    assign ready_o      = ready_r;

endmodule : rf_init_ctrl

// File: rtl/rf_riscv_mp.sv
// Multi-read-port register file with clear sweep and pending scoreboard.
// Optional write-through bypass: define RF_RISCV_MP_BYPASS_EN.
module rf_riscv_mp
    import rf_riscv_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = RF_NUM_RD
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     ready_o,
    input  logic                     write_enable_i,
    input  logic [ADDR_W-1:0]        write_addr_i,
    input  logic [DATA_W-1:0]        write_data_i,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr_i,
    output logic [NUM_RD*DATA_W-1:0] read_data_o,
    output logic [NUM_RD-1:0]        read_pend_o,
    input  logic                     pend_set_i,
    input  logic [ADDR_W-1:0]        pend_addr_i
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;

    logic              clear_en_s;
    logic [ADDR_W-1:0] clear_addr_s;
    logic              ready_s;
    logic              wr_run_s;
    logic              pend_set_s;

    rf_init_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_en_o   (clear_en_s),
        .clear_addr_o (clear_addr_s),
        .ready_o      (ready_s)
    );

    assign wr_run_s   = ready_s & write_enable_i & (write_addr_i != ZERO_ADDR);
    assign pend_set_s = ready_s & pend_set_i & (pend_addr_i != ZERO_ADDR);
    assign ready_o    = ready_s;

    // Storage write port: the sweep owns the array until ready, writeback after.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Data array is left alone; the sweep that follows clears it.
        end else if (clear_en_s) begin
            mem_r[clear_addr_s] <= {DATA_W{1'b0}};
        end else if (wr_run_s) begin
            mem_r[write_addr_i] <= write_data_i;
        end
    end

    // Scoreboard: a new issue outranks a retiring write to the same register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (pend_set_s && (pend_addr_i == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b1;
                end else if (wr_run_s && (write_addr_i == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b0;
                end
            end
            pend_r[0] <= 1'b0;
        end
    end

    // Read ports: zero latency, x0 and the sweep window read as zero.
    always_comb begin
        read_data_o = {(NUM_RD*DATA_W){1'b0}};
        read_pend_o = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (!ready_s) begin
                read_data_o[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                read_pend_o[k]                  = 1'b0;
            end else if (read_addr_i[k*ADDR_W +: ADDR_W] == ZERO_ADDR) begin
                read_data_o[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                read_pend_o[k]                  = 1'b0;
`ifdef RF_RISCV_MP_BYPASS_EN
            end else if (wr_run_s && (read_addr_i[k*ADDR_W +: ADDR_W] == write_addr_i)) begin
                read_data_o[k*DATA_W +: DATA_W] = write_data_i;
                read_pend_o[k]                  = 1'b0;
`endif
            end else begin
                read_data_o[k*DATA_W +: DATA_W] = mem_r[read_addr_i[k*ADDR_W +: ADDR_W]];
                read_pend_o[k]                  = pend_r[read_addr_i[k*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule : rf_riscv_mp
